// File: rtl/mux_scan_seq_pkg.sv
// Shared types and default widths for the mux scan sequencer.
// The defaults describe a 16:1 bit mux driven by a 4-bit select.
package mux_scan_seq_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_seq.sv
// Drives a word onto an external bit mux and steps the select over a range.
// Each position is held for dwell+1 cycles; the mux result is captured on the last one.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
#(
    parameter int DATA_W  = mux_scan_seq_pkg::DATA_W,
    parameter int SEL_W   = mux_scan_seq_pkg::SEL_W,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [DATA_W-1:0]  word_in,
    input  logic [SEL_W-1:0]   first_sel,
    input  logic [SEL_W-1:0]   last_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [DATA_W-1:0]  mux_in,
    output logic [SEL_W-1:0]   mux_sel,
    input  logic               mux_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_word,
    output logic               res_mismatch,
    output logic [SEL_W:0]     res_count,
    output logic               busy
);

    localparam logic [SEL_W-1:0]   SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]     CNT_ONE   = {{SEL_W{1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [SEL_W-1:0]     last_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 accept;
    logic                 sample;
    logic                 final_pos;

    assign start_ready = (state == IDLE);
    assign busy        = (state == SCAN);
    assign res_valid   = (state == DONE);

    always_comb begin
        accept    = 1'b0;
        sample    = 1'b0;
        final_pos = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                sample    = (dwell_cnt == '0);
                final_pos = sample && (mux_sel == last_q);
                if (final_pos)
                    state_nxt = DONE;
            end
            DONE: begin
                // Returning to IDLE here keeps start_ready low during the handshake cycle.
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_in       <= '0;
            mux_sel      <= '0;
            last_q       <= '0;
            dwell_q      <= '0;
            dwell_cnt    <= '0;
            res_word     <= '0;
            res_count    <= '0;
            res_mismatch <= 1'b0;
        end else if (accept) begin
            mux_in       <= word_in;
            mux_sel      <= first_sel;
            last_q       <= last_sel;
            dwell_q      <= dwell;
            dwell_cnt    <= dwell;
            res_word     <= '0;
            res_count    <= '0;
            res_mismatch <= 1'b0;
        end else if (busy) begin
            if (!sample) begin
                dwell_cnt <= dwell_cnt - DWELL_ONE;
            end else begin
                res_word[mux_sel] <= mux_out;
                res_count         <= res_count + CNT_ONE;
                // Only scanned positions can contribute, so unscanned bits never flag.
                res_mismatch      <= res_mismatch | (mux_out ^ mux_in[mux_sel]);
                if (!final_pos) begin
                    mux_sel   <= mux_sel + SEL_ONE;
                    dwell_cnt <= dwell_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq with an external 16:1 mux that can have bits stuck at 0.
// A per-cycle reference model is checked alongside directed literal expectations.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] word_in;
    logic [3:0]  first_sel;
    logic [3:0]  last_sel;
    logic [3:0]  dwell;
    logic [15:0] mux_in;
    logic [3:0]  mux_sel;
    logic        mux_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_word;
    logic        res_mismatch;
    logic [4:0]  res_count;
    logic        busy;
    logic [15:0] stuck;

    always #5 clk = ~clk;

    assign mux_out = mux_in[mux_sel] & ~stuck[mux_sel];

    mux_scan_seq #(.DATA_W(16), .SEL_W(4), .DWELL_W(4)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .word_in(word_in), .first_sel(first_sel), .last_sel(last_sel), .dwell(dwell),
        .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_word(res_word), .res_mismatch(res_mismatch), .res_count(res_count),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 scanning, 2 result held.
    int          m_ph;
    int          m_t;
    int          m_len;
    int          m_pos;
    int          m_d;
    bit          m_fresh;
    logic [15:0] m_word;
    logic [15:0] m_res;
    logic [3:0]  m_first;
    logic [3:0]  m_last;
    logic        m_mis;

    function automatic int positions(input logic [3:0] f, input logic [3:0] l);
        return ((int'(l) - int'(f) + 16) % 16) + 1;
    endfunction

    function automatic logic [16:0] expect_res(input logic [15:0] w, input logic [3:0] f,
                                               input logic [3:0] l, input logic [15:0] s);
        logic [15:0] r = '0;
        logic        mis = 1'b0;
        for (int k = 0; k < positions(f, l); k++) begin
            int idx = (int'(f) + k) % 16;
            r[idx] = w[idx] & ~s[idx];
            if (r[idx] != w[idx]) mis = 1'b1;
        end
        return {mis, r};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph    <= 0;
            m_fresh <= 1'b1;
        end else begin
            case (m_ph)
                0: if (start_valid) begin
                    m_ph    <= 1;
                    m_t     <= 0;
                    m_fresh <= 1'b0;
                    m_word  <= word_in;
                    m_first <= first_sel;
                    m_last  <= last_sel;
                    m_d     <= int'(dwell);
                    m_pos   <= positions(first_sel, last_sel);
                    m_len   <= positions(first_sel, last_sel) * (int'(dwell) + 1);
                    {m_mis, m_res} <= expect_res(word_in, first_sel, last_sel, stuck);
                end
                1: begin
                    m_t <= m_t + 1;
                    if (m_t + 1 == m_len) m_ph <= 2;
                end
                default: if (res_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        case (m_ph)
            0: begin
                chk("idle_start_ready", start_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_res_valid", res_valid, 0);
                if (m_fresh) begin
                    chk("rst_mux_in", mux_in, 0);
                    chk("rst_mux_sel", mux_sel, 0);
                    chk("rst_res_word", res_word, 0);
                    chk("rst_res_count", res_count, 0);
                    chk("rst_res_mismatch", res_mismatch, 0);
                end
            end
            1: begin
                chk("scan_busy", busy, 1);
                chk("scan_start_ready", start_ready, 0);
                chk("scan_res_valid", res_valid, 0);
                chk("scan_mux_in", mux_in, m_word);
                chk("scan_mux_sel", mux_sel, (int'(m_first) + m_t / (m_d + 1)) % 16);
            end
            default: begin
                chk("done_res_valid", res_valid, 1);
                chk("done_busy", busy, 0);
                chk("done_start_ready", start_ready, 0);
                chk("done_res_word", res_word, m_res);
                chk("done_res_count", res_count, m_pos);
                chk("done_res_mismatch", res_mismatch, m_mis);
                chk("done_mux_in", mux_in, m_word);
                chk("done_mux_sel", mux_sel, m_last);
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [15:0] w, input logic [3:0] f, input logic [3:0] l,
                       input logic [3:0] d);
        int g = 0;
        while (!start_ready && g < 50) begin
            step();
            g++;
        end
        chk("req_ready_timeout", start_ready, 1);
        word_in = w; first_sel = f; last_sel = l; dwell = d;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 400) begin
            step();
            n++;
        end
        chk("res_valid_timeout", res_valid, 1);
    endtask

    task automatic ack();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    int n;
    int seq[12] = '{14, 14, 14, 15, 15, 15, 0, 0, 0, 1, 1, 1};

    initial begin
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; stuck = '0;
        word_in = '0; first_sel = '0; last_sel = '0; dwell = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_start_ready", start_ready, 1);
        chk("reset_res_word", res_word, 0);

        // Full range, no dwell, healthy mux.
        req(16'hA5C3, 4'd0, 4'd15, 4'd0);
        wait_valid(n);
        chk("t1_latency", n, 16);
        chk("t1_res_word", res_word, 16'hA5C3);
        chk("t1_res_count", res_count, 16);
        chk("t1_res_mismatch", res_mismatch, 0);
        ack();

        // Wrapping range with dwell of 3 cycles.
        req(16'hFFFF, 4'd14, 4'd1, 4'd2);
        for (int i = 0; i < 12; i++) begin
            chk("t2_sel_seq", mux_sel, seq[i]);
            step();
        end
        chk("t2_res_valid", res_valid, 1);
        chk("t2_res_word", res_word, 16'hC003);
        chk("t2_res_count", res_count, 4);
        ack();

        // Single position with bit 7 stuck low, then a stalled consumer.
        stuck = 16'h0080;
        req(16'h0080, 4'd7, 4'd7, 4'd0);
        wait_valid(n);
        chk("t3_latency", n, 1);
        chk("t3_res_count", res_count, 1);
        chk("t3_res_mismatch", res_mismatch, 1);
        chk("t3_res_word", res_word, 16'h0000);
        start_valid = 1'b1;
        word_in = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_ready", start_ready, 0);
            chk("t4_hold_count", res_count, 1);
            chk("t4_hold_mismatch", res_mismatch, 1);
            chk("t4_hold_mux_in", mux_in, 16'h0080);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("t4_after_ack_ready", start_ready, 1);
        chk("t4_after_ack_busy", busy, 0);
        start_valid = 1'b0;
        stuck = '0;

        // Reset during the 6th scan cycle.
        req(16'hA5C3, 4'd0, 4'd15, 4'd1);
        repeat (5) step();
        chk("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_mux_in", mux_in, 0);
        chk("t5_rst_mux_sel", mux_sel, 0);
        chk("t5_rst_res_count", res_count, 0);
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (res_valid) n++;
        end
        chk("t5_no_result", n, 0);
        chk("t5_start_ready", start_ready, 1);

        // Inputs change mid-scan; result follows the accepted values.
        req(16'h1234, 4'd2, 4'd9, 4'd1);
        repeat (3) step();
        word_in = 16'hFFFF; first_sel = 4'd0; last_sel = 4'd3; dwell = 4'd5;
        wait_valid(n);
        chk("t6_latency", n, 13);
        chk("t6_res_word", res_word, 16'h0234);
        chk("t6_res_count", res_count, 8);
        chk("t6_res_mismatch", res_mismatch, 0);
        ack();

        // Full wrap starting mid-word with a stuck bit inside the range.
        stuck = 16'h0010;
        req(16'h00F0, 4'd5, 4'd4, 4'd0);
        wait_valid(n);
        chk("t7_latency", n, 16);
        chk("t7_res_word", res_word, 16'h00E0);
        chk("t7_res_count", res_count, 16);
        chk("t7_res_mismatch", res_mismatch, 1);
        ack();
        stuck = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
